// File: rtl/hand_centroid_tracker_if.sv
// Result bus from the centroid tracker to the gesture classifier / arm controller.
// The master drives the payload and result_valid; the slave returns result_ready.
interface hand_centroid_tracker_if #(
  parameter int CNT_W = 20
);
  logic             result_valid;
  logic             result_ready;
  logic [15:0]      cent_x;
  logic [15:0]      cent_y;
  logic             obj_found;
  logic [CNT_W-1:0] pix_count;
  logic [15:0]      bbox_min_x;
  logic [15:0]      bbox_max_x;
  logic [15:0]      bbox_min_y;
  logic [15:0]      bbox_max_y;

  modport master (
    output result_valid, cent_x, cent_y, obj_found, pix_count,
    output bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
    input  result_ready
  );

  modport slave (
    input  result_valid, cent_x, cent_y, obj_found, pix_count,
    input  bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
    output result_ready
  );
endinterface

// File: rtl/hand_centroid_tracker.sv
// Per-frame hand-pixel centroid with a sequential restoring divider.
// Define CENTROID_BBOX_EN to build the bounding-box tracker.
module hand_centroid_tracker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 20,
  parameter int SUM_W      = 30,
  parameter int MIN_PIXELS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  pixel_valid,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic [15:0]           pixel_x,
  input  logic [15:0]           pixel_y,
  input  logic [DATA_WIDTH-1:0] th_lo,
  input  logic [DATA_WIDTH-1:0] th_hi,
  hand_centroid_tracker_if.master res,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IT_W = $clog2(SUM_W);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PIXELS);
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE, DIVX, DIVY, RESULT} state_e;

  state_e state_q;

  logic [DATA_WIDTH-1:0] lo_q, hi_q, lo_eff, hi_eff;
  logic                  match, clr, fe_q;
  logic [CNT_W-1:0]      cnt_q, cnt_base, cnt_d;
  logic [CNT_W:0]        cnt_inc;
  logic [SUM_W-1:0]      sx_q, sy_q, sx_base, sy_base, sx_d, sy_d;
  logic [SUM_W:0]        sx_add, sy_add;

  logic [CNT_W-1:0]      snap_cnt_q;
  logic [SUM_W-1:0]      snap_sy_q;
  logic [SUM_W-1:0]      quo_q, quo_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [CNT_W:0]        rem_sh;
  logic [IT_W-1:0]       it_q;
  logic                  div_last, enter_nf, enter_f;
  logic [15:0]           cx_q;

  logic                  rv_q, found_q, busy_q, ovr_q;
  logic [15:0]           ocx_q, ocy_q;
  logic [CNT_W-1:0]      opix_q;

  always_comb begin
    lo_eff   = frame_start ? th_lo : lo_q;
    hi_eff   = frame_start ? th_hi : hi_q;
    match    = pixel_valid && (pixel_data >= lo_eff) && (pixel_data <= hi_eff);
    clr      = frame_start || fe_q;
    cnt_base = clr ? '0 : cnt_q;
    sx_base  = clr ? '0 : sx_q;
    sy_base  = clr ? '0 : sy_q;
    cnt_inc  = {1'b0, cnt_base} + 1'b1;
    sx_add   = {1'b0, sx_base} + (SUM_W+1)'(pixel_x);
    sy_add   = {1'b0, sy_base} + (SUM_W+1)'(pixel_y);
    cnt_d    = cnt_base;
    sx_d     = sx_base;
    sy_d     = sy_base;
    if (match) begin
      cnt_d = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
      sx_d  = sx_add[SUM_W] ? '1 : sx_add[SUM_W-1:0];
      sy_d  = sy_add[SUM_W] ? '1 : sy_add[SUM_W-1:0];
    end
  end

  // One restoring step: the quotient shifts into the vacated dividend bits.
  always_comb begin
    rem_sh = {rem_q, quo_q[SUM_W-1]};
    if (rem_sh >= {1'b0, snap_cnt_q}) begin
      rem_d = CNT_W'(rem_sh - {1'b0, snap_cnt_q});
      quo_d = {quo_q[SUM_W-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[CNT_W-1:0];
      quo_d = {quo_q[SUM_W-2:0], 1'b0};
    end
  end

  assign div_last = (it_q == IT_LAST);
  assign enter_nf = (state_q == IDLE) && fe_q && (cnt_q < MIN_C);
  assign enter_f  = (state_q == DIVY) && div_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      fe_q       <= 1'b0;
      cnt_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      snap_cnt_q <= '0;
      snap_sy_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      it_q       <= '0;
      cx_q       <= '0;
      rv_q       <= 1'b0;
      found_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ocx_q      <= '0;
      ocy_q      <= '0;
      opix_q     <= '0;
    end else begin
      fe_q  <= frame_end;
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      if (frame_start) begin
        lo_q <= th_lo;
        hi_q <= th_hi;
      end
      if (fe_q && (state_q != IDLE)) ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (fe_q) begin
            snap_cnt_q <= cnt_q;
            snap_sy_q  <= sy_q;
            quo_q      <= sx_q;
            rem_q      <= '0;
            it_q       <= '0;
            if (cnt_q >= MIN_C) begin
              state_q <= DIVX;
              busy_q  <= 1'b1;
            end else begin
              state_q <= RESULT;
              rv_q    <= 1'b1;
              found_q <= 1'b0;
              ocx_q   <= '0;
              ocy_q   <= '0;
              opix_q  <= cnt_q;
            end
          end
        end
        DIVX: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          it_q  <= it_q + 1'b1;
          if (div_last) begin
            cx_q    <= quo_d[15:0];
            quo_q   <= snap_sy_q;
            rem_q   <= '0;
            it_q    <= '0;
            state_q <= DIVY;
          end
        end
        DIVY: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          it_q  <= it_q + 1'b1;
          if (div_last) begin
            state_q <= RESULT;
            busy_q  <= 1'b0;
            rv_q    <= 1'b1;
            found_q <= 1'b1;
            ocx_q   <= cx_q;
            ocy_q   <= quo_d[15:0];
            opix_q  <= snap_cnt_q;
          end
        end
        RESULT: begin
          if (res.result_ready) begin
            rv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res.result_valid = rv_q;
  assign res.cent_x       = ocx_q;
  assign res.cent_y       = ocy_q;
  assign res.obj_found    = found_q;
  assign res.pix_count    = opix_q;
  assign busy             = busy_q;
  assign overrun          = ovr_q;

`ifdef CENTROID_BBOX_EN
  logic [15:0] mnx_q, mxx_q, mny_q, mxy_q;
  logic [15:0] mnx_b, mxx_b, mny_b, mxy_b;
  logic [15:0] mnx_d, mxx_d, mny_d, mxy_d;
  logic [15:0] smnx_q, smxx_q, smny_q, smxy_q;
  logic [15:0] omnx_q, omxx_q, omny_q, omxy_q;

  always_comb begin
    mnx_b = clr ? 16'hFFFF : mnx_q;
    mxx_b = clr ? 16'h0000 : mxx_q;
    mny_b = clr ? 16'hFFFF : mny_q;
    mxy_b = clr ? 16'h0000 : mxy_q;
    mnx_d = (match && (pixel_x < mnx_b)) ? pixel_x : mnx_b;
    mxx_d = (match && (pixel_x > mxx_b)) ? pixel_x : mxx_b;
    mny_d = (match && (pixel_y < mny_b)) ? pixel_y : mny_b;
    mxy_d = (match && (pixel_y > mxy_b)) ? pixel_y : mxy_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mnx_q  <= 16'hFFFF;
      mxx_q  <= '0;
      mny_q  <= 16'hFFFF;
      mxy_q  <= '0;
      smnx_q <= '0;
      smxx_q <= '0;
      smny_q <= '0;
      smxy_q <= '0;
      omnx_q <= '0;
      omxx_q <= '0;
      omny_q <= '0;
      omxy_q <= '0;
    end else begin
      mnx_q <= mnx_d;
      mxx_q <= mxx_d;
      mny_q <= mny_d;
      mxy_q <= mxy_d;
      if (fe_q && (state_q == IDLE)) begin
        smnx_q <= mnx_q;
        smxx_q <= mxx_q;
        smny_q <= mny_q;
        smxy_q <= mxy_q;
      end
      if (enter_nf) begin
        omnx_q <= '0;
        omxx_q <= '0;
        omny_q <= '0;
        omxy_q <= '0;
      end else if (enter_f) begin
        omnx_q <= smnx_q;
        omxx_q <= smxx_q;
        omny_q <= smny_q;
        omxy_q <= smxy_q;
      end
    end
  end

  assign res.bbox_min_x = omnx_q;
  assign res.bbox_max_x = omxx_q;
  assign res.bbox_min_y = omny_q;
  assign res.bbox_max_y = omxy_q;
`else
  assign res.bbox_min_x = '0;
  assign res.bbox_max_x = '0;
  assign res.bbox_min_y = '0;
  assign res.bbox_max_y = '0;
`endif

endmodule

// File: tb/tb_hand_centroid_tracker.sv
// Directed vector bench for hand_centroid_tracker (MIN_PIXELS=16).
// Table of 4x4-block frames plus hand sequences for overrun, edge pixels, reset.
module tb_hand_centroid_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pixel_data;
  logic        pixel_valid, frame_start, frame_end;
  logic [15:0] pixel_x, pixel_y;
  logic [7:0]  th_lo, th_hi;
  logic        busy, overrun;

  hand_centroid_tracker_if #(.CNT_W(20)) rif ();

  hand_centroid_tracker #(
    .DATA_WIDTH(8), .CNT_W(20), .SUM_W(30), .MIN_PIXELS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .frame_end(frame_end),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .th_lo(th_lo), .th_hi(th_hi),
    .res(rif), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, lo, hi, blk, bg, n;
    int cnt, found, cx, cy, lat;
  } vec_t;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input int d, input int x, input int y,
                       input bit v, input bit fs, input bit fe);
    pixel_data  = 8'(d);
    pixel_x     = 16'(x);
    pixel_y     = 16'(y);
    pixel_valid = v;
    frame_start = fs;
    frame_end   = fe;
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    th_lo = 8'(v.lo);
    th_hi = 8'(v.hi);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++)
      drive(i < v.n ? v.blk : v.bg, v.x0 + i % 4, v.y0 + i / 4, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(v.bg, 100 + i, 5, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
  endtask

  // Called one negedge after the frame_end cycle; lat counts cycles from frame_end.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!rif.result_valid && lat < 120) begin
      @(negedge clk);
      lat++;
    end
    if (!rif.result_valid) lat = -1;
  endtask

  task automatic handshake(input string nm);
    rif.result_ready = 1'b1;
    @(negedge clk);
    rif.result_ready = 1'b0;
    chk({nm, "_vld_drop"}, rif.result_valid, 0);
  endtask

  task automatic chk_bbox(input string nm, input vec_t v, input bit found);
    int e0, e1, e2, e3;
    e0 = 0; e1 = 0; e2 = 0; e3 = 0;
`ifdef CENTROID_BBOX_EN
    if (found) begin
      e0 = v.x0; e1 = v.x0 + 3; e2 = v.y0; e3 = v.y0 + 3;
    end
`endif
    chk({nm, "_bminx"}, rif.bbox_min_x, e0);
    chk({nm, "_bmaxx"}, rif.bbox_max_x, e1);
    chk({nm, "_bminy"}, rif.bbox_min_y, e2);
    chk({nm, "_bmaxy"}, rif.bbox_max_y, e3);
  endtask

  vec_t vt[7];
  vec_t base;

  initial begin
    int lat, bad;
    vt[0] = '{10, 20, 100, 200, 150, 0, 16, 16, 1, 11, 21, 62};
    vt[1] = '{10, 20, 100, 200, 150, 0, 15, 15, 0, 0, 0, 2};
    vt[2] = '{10, 20, 200, 100, 255, 255, 16, 0, 0, 0, 0, 2};
    vt[3] = '{10, 20, 100, 100, 100, 0, 16, 16, 1, 11, 21, 62};
    vt[4] = '{10, 20, 50, 99, 100, 0, 16, 0, 0, 0, 0, 2};
    vt[5] = '{1000, 300, 100, 200, 150, 0, 16, 16, 1, 1001, 301, 62};
    vt[6] = '{10, 20, 100, 200, 200, 0, 16, 16, 1, 11, 21, 62};
    base  = vt[0];

    rst_n = 1'b0;
    pixel_data = '0; pixel_valid = 1'b0;
    frame_start = 1'b0; frame_end = 1'b0;
    pixel_x = '0; pixel_y = '0;
    th_lo = '0; th_hi = '0;
    rif.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", rif.result_valid, 0);
    chk("rst_cx", rif.cent_x, 0);
    chk("rst_pix", rif.pix_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);

    for (int k = 0; k < 7; k++) begin
      string nm;
      nm = $sformatf("v%0d", k);
      send_frame(vt[k]);
      wait_valid(lat);
      chk({nm, "_lat"}, lat, vt[k].lat);
      chk({nm, "_pix"}, rif.pix_count, vt[k].cnt);
      chk({nm, "_found"}, rif.obj_found, vt[k].found);
      chk({nm, "_cx"}, rif.cent_x, vt[k].cx);
      chk({nm, "_cy"}, rif.cent_y, vt[k].cy);
      chk_bbox(nm, vt[k], vt[k].found != 0);
      handshake(nm);
    end

    // Back-pressure: hold the result, drop a second frame, then release.
    send_frame(base);
    repeat (4) @(negedge clk);
    chk("busy_in_div", busy, 1);
    wait_valid(lat);
    chk("hold_lat", lat, 62 - 4);
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (c == 10) begin
        vec_t v2;
        v2 = base; v2.n = 15;
        send_frame(v2);
        c += 22;
      end
      if (!rif.result_valid || rif.cent_x != 16'd11 || rif.cent_y != 16'd21 ||
          rif.pix_count != 20'd16 || !rif.obj_found) bad++;
      @(negedge clk);
    end
    chk("hold_stable", bad, 0);
    chk("hold_ovr", overrun, 1);
    chk("hold_pix", rif.pix_count, 16);
    handshake("hold");
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (rif.result_valid) bad++;
    end
    chk("dropped_no_result", bad, 0);

    // Matching pixels on the frame_start and frame_end cycles both count;
    // thresholds changed mid-frame must be ignored.
    th_lo = 8'd100; th_hi = 8'd200;
    drive(150, 10, 20, 1, 1, 0);
    th_lo = 8'd0; th_hi = 8'd0;
    for (int i = 1; i < 15; i++) drive(150, 10 + i % 4, 20 + i / 4, 1, 0, 0);
    drive(0, 50, 50, 1, 0, 0);
    drive(150, 13, 23, 1, 0, 1);
    wait_valid(lat);
    chk("edge_lat", lat, 62);
    chk("edge_pix", rif.pix_count, 16);
    chk("edge_cx", rif.cent_x, 11);
    chk("edge_cy", rif.cent_y, 21);
    handshake("edge");

    // Reset during DIVX aborts the frame.
    send_frame(base);
    repeat (28) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_pix", rif.pix_count, 0);
    chk("mid_rst_cx", rif.cent_x, 0);
    chk("mid_rst_found", rif.obj_found, 0);
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (rif.result_valid) bad++;
    end
    chk("mid_rst_no_result", bad, 0);
    send_frame(vt[5]);
    wait_valid(lat);
    chk("post_rst_lat", lat, 62);
    chk("post_rst_cx", rif.cent_x, 1001);
    chk("post_rst_cy", rif.cent_y, 301);
    chk("post_rst_pix", rif.pix_count, 16);
    handshake("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hand_centroid_tracker.md
Name: hand_centroid_tracker

Overview:
Consumes the grayscale pixel stream from the camera capture stage: pixel_data, pixel_valid, frame_start, frame_end and pixel_x/pixel_y. Each pixel is classified as "hand" when it falls inside a programmable intensity window. The block accumulates count, sum_x and sum_y per frame, and at frame end computes the integer centroid with a sequential divider. It presents one result per frame on a valid/ready handshake to the gesture classifier / arm controller. Inputs are synchronous to clk; any CDC from the pixel clock sits outside this block.

Parameters:
DATA_WIDTH, 8, pixel intensity width
CNT_W, 20, hand-pixel counter width (covers 640x480)
SUM_W, 30, coordinate-sum accumulator width; also the divider iteration count
MIN_PIXELS, 64, minimum hand pixels for a valid detection

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pixel_data  in  DATA_WIDTH  grayscale pixel
pixel_valid  in  1  pixel_data/pixel_x/pixel_y valid this cycle
frame_start  in  1  one-cycle pulse, frame begins
frame_end  in  1  one-cycle pulse, frame complete
pixel_x  in  16  pixel column
pixel_y  in  16  pixel row
th_lo  in  DATA_WIDTH  inclusive lower threshold
th_hi  in  DATA_WIDTH  inclusive upper threshold
result_ready  in  1  consumer accepts result
result_valid  out  1  result available
cent_x  out  16  centroid column (floor)
cent_y  out  16  centroid row (floor)
obj_found  out  1  pix_count >= MIN_PIXELS
pix_count  out  CNT_W  hand pixels in the frame
bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y  out  16 each  bounding box (optional feature)
busy  out  1  divider running
overrun  out  1  sticky: a frame result was dropped

Behaviour:
- Reset: synchronous on rst_n=0 at a clk edge. All outputs go to 0. Accumulators clear, FSM enters IDLE, overrun clears. Reset mid-division aborts the division with no result.
- Thresholds: th_lo/th_hi are latched on frame_start and held for the whole frame. Match condition: pixel_valid and th_lo <= pixel_data <= th_hi. If th_lo > th_hi, no pixel matches.
- Accumulation: on a match, cnt += 1, sum_x += pixel_x, sum_y += pixel_y. Accumulators saturate at all-ones; they never wrap.
- frame_start clears the accumulators. If frame_start and a matching pixel occur in the same cycle, the clear happens and that pixel counts as the first of the new frame.
- frame_end: a matching pixel in the same cycle is included. Next edge: if the FSM is IDLE, the snapshot registers load cnt/sum_x/sum_y (and the bbox) and the accumulators clear. If the FSM is not IDLE, the frame is discarded, overrun is set, and the accumulators still clear.
- A frame_end with no preceding frame_start is still processed using whatever has accumulated since reset or since the last clear.
- FSM states: IDLE, DIVX, DIVY, RESULT.
  - IDLE -> DIVX on snapshot when snap_cnt >= MIN_PIXELS.
  - IDLE -> RESULT directly when snap_cnt < MIN_PIXELS; outputs obj_found=0, cent_x=cent_y=0, pix_count=snap_cnt.
  - DIVX: restoring divide sum_x/cnt, one quotient bit per cycle, exactly SUM_W cycles, then -> DIVY.
  - DIVY: same for sum_y, SUM_W cycles, then -> RESULT.
  - RESULT: result_valid=1 and outputs held stable until result_valid && result_ready, then -> IDLE with result_valid=0 on the next edge.
  - busy=1 in DIVX/DIVY only.
- Latency: frame_end sampled in cycle T. Found case: result_valid high from cycle T+2+2*SUM_W (T+62 at default). Not-found case: from cycle T+2.
- Quotient is floor(sum/cnt), truncated to 16 bits. Since pixel_x <= 65535 the quotient always fits. Divide-by-zero cannot occur because MIN_PIXELS >= 1 is required.
- Outputs change only when entering RESULT.

Optional Feature:
Macro CENTROID_BBOX_EN.
- Defined: track min/max of pixel_x/pixel_y over matching pixels, reset on frame_start to min=16'hFFFF, max=0. Snapshot at frame_end and output in RESULT. Not-found case outputs all four as 0.
- Undefined: no bbox registers are built; the four bbox outputs are tied to 0.

Test Plan:
- th_lo=100, th_hi=200; 4x4 block of pixel_data=150 at x=10..13, y=20..23 in an otherwise-0 frame; MIN_PIXELS=16 -> after frame_end, result_valid at T+62, cent_x=11, cent_y=21, pix_count=16, obj_found=1, bbox (10,13,20,23) with CENTROID_BBOX_EN.
- Same frame with only 15 matching pixels -> result_valid at T+2, obj_found=0, cent_x=cent_y=0, pix_count=15.
- Hold result_ready=0 for 200 cycles -> outputs stable; second frame_end during that window -> overrun=1, first result unchanged; result_ready=1 -> one transfer, then IDLE.
- Matching pixel in the same cycle as frame_start, and another in the same cycle as frame_end -> both counted (pix_count includes both).
- rst_n=0 for one cycle at T+30 during DIVX -> next cycle all outputs 0, no result_valid for that frame, the next frame is processed normally.
- th_lo=200, th_hi=100 with a full-intensity frame -> pix_count=0, obj_found=0.
